// File: rtl/pmod_i2s2_rx_pkg.sv
// Shared constants, capture-state type and saturation helper for the Pmod I2S2 line-in receiver.
package pmod_i2s2_rx_pkg;

    localparam int I2S2_SAMPLE_WIDTH = 24;
    localparam int I2S2_SLOTS_PER_CH = 32;
    localparam int I2S2_DIV_BITS     = 9;
    localparam int I2S2_VALID_CNT    = 453;

    localparam int I2S2_SLOT_BITS    = $clog2(I2S2_SLOTS_PER_CH);
    localparam int I2S2_DC_WIDTH     = 32;
    localparam int I2S2_DC_SHIFT     = 8;

    typedef logic [I2S2_DIV_BITS-1:0]  div_cnt_t;
    typedef logic [I2S2_SLOT_BITS-1:0] slot_t;

    // Register-load point: the edge that moves div_cnt onto the valid count.
    localparam div_cnt_t I2S2_LOAD_CNT  = div_cnt_t'(I2S2_VALID_CNT - 1);
    localparam div_cnt_t I2S2_HALF_LAST = div_cnt_t'(I2S2_SLOTS_PER_CH * 8 - 1);
    localparam slot_t    I2S2_SLOT_MSB  = slot_t'(1);
    localparam slot_t    I2S2_SLOT_LSB  = slot_t'(I2S2_SAMPLE_WIDTH);

    typedef enum logic [1:0] {
        CAP_IDLE,
        CAP_LEFT,
        CAP_RIGHT
    } cap_state_t;

    function automatic logic signed [I2S2_SAMPLE_WIDTH-1:0] sat_sample(
        input logic signed [I2S2_DC_WIDTH-1:0] v
    );
        if (v > 32'sd8388607) begin
            return 24'sh7FFFFF;
        end else if (v < -32'sd8388608) begin
            return 24'sh800000;
        end else begin
            return $signed(v[I2S2_SAMPLE_WIDTH-1:0]);
        end
    endfunction

endpackage

// File: rtl/i2s_dc_block.sv
// First-order DC blocker, y = x - x_prev + y_prev - (y_prev >>> 8), 32-bit state, saturated output.
module i2s_dc_block
    import pmod_i2s2_rx_pkg::*;
(
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic                                sample_valid,
    input  logic signed [I2S2_SAMPLE_WIDTH-1:0] sample,
    output logic                                filt_valid,
    output logic signed [I2S2_SAMPLE_WIDTH-1:0] filt
);

    logic signed [I2S2_DC_WIDTH-1:0] x_ext;
    logic signed [I2S2_DC_WIDTH-1:0] x_prev;
    logic signed [I2S2_DC_WIDTH-1:0] y_prev;
    logic signed [I2S2_DC_WIDTH-1:0] y_next;

    assign x_ext  = {{(I2S2_DC_WIDTH - I2S2_SAMPLE_WIDTH){sample[I2S2_SAMPLE_WIDTH-1]}}, sample};
    assign y_next = x_ext - x_prev + y_prev - (y_prev >>> I2S2_DC_SHIFT);

    // Feedback keeps full precision; only the visible output is clamped.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            x_prev     <= '0;
            y_prev     <= '0;
            filt       <= '0;
            filt_valid <= 1'b0;
        end else begin
            filt_valid <= sample_valid;
            if (sample_valid) begin
                x_prev <= x_ext;
                y_prev <= y_next;
                filt   <= sat_sample(y_next);
            end
        end
    end

endmodule

// File: rtl/pmod_i2s2_rx.sv
// Pmod I2S2 line-in receiver: generates MCLK/SCLK/LRCK and deserialises 24-bit stereo I2S frames.
// Define I2S2_RX_DCBLOCK_EN to insert a per-channel DC blocker (one extra cycle of latency).
module pmod_i2s2_rx
    import pmod_i2s2_rx_pkg::*;
(
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic                                sdout_in,
    output logic                                mclk_out,
    output logic                                sclk_out,
    output logic                                lrck_out,
    output logic signed [I2S2_SAMPLE_WIDTH-1:0] left_out,
    output logic signed [I2S2_SAMPLE_WIDTH-1:0] right_out,
    output logic                                valid_out
);

    div_cnt_t                         div_cnt;
    slot_t                            slot;
    cap_state_t                       state;
    cap_state_t                       state_next;
    logic                             bit_strobe;
    logic                             shift_left;
    logic                             shift_right;
    logic                             load_pair;
    logic [I2S2_SAMPLE_WIDTH-1:0]     left_sr;
    logic [I2S2_SAMPLE_WIDTH-1:0]     right_sr;
    logic signed [I2S2_SAMPLE_WIDTH-1:0] cap_left;
    logic signed [I2S2_SAMPLE_WIDTH-1:0] cap_right;
    logic                             cap_valid;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Clocks come straight from counter flops, so they cannot glitch.
    assign mclk_out = div_cnt[0];
    assign sclk_out = div_cnt[2];
    assign lrck_out = div_cnt[I2S2_DIV_BITS-1];
    assign slot     = div_cnt[I2S2_DIV_BITS-2:3];

    // Sample on the edge leaving phase 3 of a slot, i.e. the SCLK rising edge.
    assign bit_strobe = (div_cnt[2:0] == 3'b011) &&
                        (slot >= I2S2_SLOT_MSB) && (slot <= I2S2_SLOT_LSB);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= CAP_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next  = state;
        shift_left  = 1'b0;
        shift_right = 1'b0;
        load_pair   = 1'b0;
        unique case (state)
            CAP_IDLE: begin
                if (div_cnt == '0) state_next = CAP_LEFT;
            end
            CAP_LEFT: begin
                shift_left = bit_strobe && !lrck_out;
                if (div_cnt == I2S2_HALF_LAST) state_next = CAP_RIGHT;
            end
            CAP_RIGHT: begin
                shift_right = bit_strobe && lrck_out;
                load_pair   = (div_cnt == I2S2_LOAD_CNT);
                if (div_cnt == '1) state_next = CAP_LEFT;
            end
            default: state_next = CAP_IDLE;
        endcase
    end

    // NOTE: the shift registers are reset too, so a frame cut short by reset leaves no residue.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            left_sr  <= '0;
            right_sr <= '0;
        end else begin
            if (shift_left)  left_sr  <= {left_sr[I2S2_SAMPLE_WIDTH-2:0], sdout_in};
            if (shift_right) right_sr <= {right_sr[I2S2_SAMPLE_WIDTH-2:0], sdout_in};
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cap_left  <= '0;
            cap_right <= '0;
            cap_valid <= 1'b0;
        end else begin
            cap_valid <= load_pair;
            if (load_pair) begin
                cap_left  <= $signed(left_sr);
                cap_right <= $signed(right_sr);
            end
        end
    end

`ifdef I2S2_RX_DCBLOCK_EN
    logic left_filt_valid;
    logic right_filt_valid;

    i2s_dc_block u_dc_left (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .sample_valid (cap_valid),
        .sample       (cap_left),
        .filt_valid   (left_filt_valid),
        .filt         (left_out)
    );

    i2s_dc_block u_dc_right (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .sample_valid (cap_valid),
        .sample       (cap_right),
        .filt_valid   (right_filt_valid),
        .filt         (right_out)
    );

    assign valid_out = left_filt_valid & right_filt_valid;
`else
    assign left_out  = cap_left;
    assign right_out = cap_right;
    assign valid_out = cap_valid;
`endif

endmodule

// File: tb/tb_pmod_i2s2_rx.sv
// Self-checking bench for pmod_i2s2_rx: ADC frame model, directed table, random frames, mid-frame reset.
module tb_pmod_i2s2_rx;

`ifdef I2S2_RX_DCBLOCK_EN
    localparam int VALID_AT = 454;
`else
    localparam int VALID_AT = 453;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sdout = 1'b0;
    logic        mclk_out;
    logic        sclk_out;
    logic        lrck_out;
    logic [23:0] left_out;
    logic [23:0] right_out;
    logic        valid_out;

    pmod_i2s2_rx dut (
        .clk_in    (clk),
        .rst_in    (rst),
        .sdout_in  (sdout),
        .mclk_out  (mclk_out),
        .sclk_out  (sclk_out),
        .lrck_out  (lrck_out),
        .left_out  (left_out),
        .right_out (right_out),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    // fill: 0 = zeros, 1 = ones, 2 = random in the unused slots
    typedef struct {
        string       name;
        logic [23:0] l;
        logic [23:0] r;
        logic [1:0]  fill;
        logic [23:0] exp_l;
        logic [23:0] exp_r;
    } vec_t;

    typedef struct {
        string       name;
        logic [23:0] l;
        logic [23:0] r;
    } exp_t;

    vec_t stim_q[$];
    exp_t exp_q[$];
    vec_t cur;

    int n_checks = 0;
    int n_fail   = 0;
    int frames_done = 0;
    int cyc = 0;

    logic [8:0]  tb_cnt;
    logic [23:0] hold_l = '0;
    logic [23:0] hold_r = '0;
    logic        mclk_q = 1'b0, sclk_q = 1'b0, lrck_q = 1'b0, valid_q = 1'b0;
    int          mclk_last = -1, sclk_last = -1, lrck_last = -1, valid_last = -1;

    longint dc_xp[2];
    longint dc_yp[2];

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%06h, want 0x%06h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [23:0] l, input logic [23:0] r,
                                input logic [1:0] fill);
        vec_t v;
        v.name  = name;
        v.l     = l;
        v.r     = r;
        v.fill  = fill;
        v.exp_l = l;   // raw two's complement bits, no rescaling
        v.exp_r = r;
        return v;
    endfunction

    // DC blocker reference: plain integer recurrence with 32-bit wrap and 24-bit clamp.
    function automatic logic [23:0] dc_model(input int ch, input logic [23:0] x);
        longint xs = longint'($signed(x));
        longint y  = xs - dc_xp[ch] + dc_yp[ch] - (dc_yp[ch] >>> 8);
        y = longint'(int'(y));
        dc_xp[ch] = xs;
        dc_yp[ch] = y;
        if (y > 64'sd8388607)  y = 64'sd8388607;
        if (y < -64'sd8388608) y = -64'sd8388608;
        return 24'(y);
    endfunction

    task automatic push_expect(input vec_t v);
        exp_t e;
        e.name = v.name;
`ifdef I2S2_RX_DCBLOCK_EN
        e.l = dc_model(0, v.l);
        e.r = dc_model(1, v.r);
`else
        e.l = v.exp_l;
        e.r = v.exp_r;
`endif
        exp_q.push_back(e);
    endtask

    // Frame position as seen by the ADC: restarts at 0 with reset, 512 cycles per frame.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cnt <= '0;
        else     tb_cnt <= tb_cnt + 9'd1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: new frame at position 0, one bit per 8-cycle slot, MSB in slot 1.
    always @(negedge clk) begin
        if (!rst) begin
            int slot;
            logic [23:0] word;
            if (tb_cnt == 9'd0) begin
                if (stim_q.size() > 0) cur = stim_q.pop_front();
                else cur = mk("idle", 24'($urandom), 24'($urandom), 2'd2);
                push_expect(cur);
            end
            slot = int'(tb_cnt[7:3]);
            word = tb_cnt[8] ? cur.r : cur.l;
            if (slot >= 1 && slot <= 24) sdout = word[24 - slot];
            else if (cur.fill == 2'd0)   sdout = 1'b0;
            else if (cur.fill == 2'd1)   sdout = 1'b1;
            else                         sdout = 1'($urandom_range(0, 1));
        end
    end

    // Output monitor: pulse timing, data, hold behaviour and clock periods.
    always @(negedge clk) begin
        if (!rst) begin
            logic exp_v;
            exp_t e;
            exp_v = (int'(tb_cnt) == VALID_AT) && (exp_q.size() > 0);
            check("valid_timing", 24'(valid_out), 24'(exp_v));
            if (exp_v) begin
                e = exp_q.pop_front();
                check({e.name, "_left"},  left_out,  e.l);
                check({e.name, "_right"}, right_out, e.r);
                hold_l = e.l;
                hold_r = e.r;
                frames_done++;
            end else if (tb_cnt == 9'd100) begin
                check("hold_left",  left_out,  hold_l);
                check("hold_right", right_out, hold_r);
            end
            if (mclk_out && !mclk_q) begin
                if (mclk_last >= 0) check("mclk_period", 24'(cyc - mclk_last), 24'd2);
                mclk_last = cyc;
            end
            if (sclk_out && !sclk_q) begin
                if (sclk_last >= 0) check("sclk_period", 24'(cyc - sclk_last), 24'd8);
                sclk_last = cyc;
            end
            if (lrck_out && !lrck_q) begin
                if (lrck_last >= 0) check("lrck_period", 24'(cyc - lrck_last), 24'd512);
                lrck_last = cyc;
            end
            if (valid_out && !valid_q) begin
                if (valid_last >= 0) check("valid_spacing", 24'(cyc - valid_last), 24'd512);
                valid_last = cyc;
            end
            mclk_q  = mclk_out;
            sclk_q  = sclk_out;
            lrck_q  = lrck_out;
            valid_q = valid_out;
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_left"},  left_out,  24'h0);
        check({tag, "_right"}, right_out, 24'h0);
        check({tag, "_valid"}, 24'(valid_out), 24'h0);
        check({tag, "_mclk"},  24'(mclk_out),  24'h0);
        check({tag, "_sclk"},  24'(sclk_out),  24'h0);
        check({tag, "_lrck"},  24'(lrck_out),  24'h0);
    endtask

    task automatic wait_frames(input int target, input string tag);
        int budget = (target - frames_done + 2) * 512;
        for (int i = 0; i < budget && frames_done < target; i++) @(negedge clk);
        check(tag, 24'(frames_done), 24'(target));
    endtask

    task automatic clear_trackers();
        mclk_q = 1'b0; sclk_q = 1'b0; lrck_q = 1'b0; valid_q = 1'b0;
        mclk_last = -1; sclk_last = -1; lrck_last = -1; valid_last = -1;
        hold_l = '0;
        hold_r = '0;
        dc_xp = '{0, 0};
        dc_yp = '{0, 0};
    endtask

    initial begin
        vec_t tbl[8];
        int   target;
        bit   hit;

        tbl[0] = mk("s1_mixed",     24'h123456, 24'hFEDCBA, 2'd2);
        tbl[1] = mk("s3_fill_ones", 24'h000000, 24'h000000, 2'd1);
        tbl[2] = mk("full_scale",   24'h7FFFFF, 24'h800000, 2'd0);
        tbl[3] = mk("one_minus1",   24'h000001, 24'hFFFFFF, 2'd1);
        tbl[4] = mk("alternating",  24'hAAAAAA, 24'h555555, 2'd2);
        tbl[5] = mk("dc_const_0",   24'h100000, 24'h100000, 2'd0);
        tbl[6] = mk("dc_const_1",   24'h100000, 24'h100000, 2'd0);
        tbl[7] = mk("dc_const_2",   24'h100000, 24'h100000, 2'd0);

        clear_trackers();
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check_reset_state("reset_state");

        foreach (tbl[i]) stim_q.push_back(tbl[i]);
        for (int i = 0; i < 20; i++)
            stim_q.push_back(mk("rand", 24'($urandom), 24'($urandom), 2'd2));
        target = stim_q.size();

        @(posedge clk);
        #2 rst = 1'b0;
        wait_frames(target, "frames_received");

        // Reset in the middle of the right-channel shift of a frame that must never appear.
        stim_q.push_back(mk("aborted", 24'($urandom) | 24'h1, 24'($urandom) | 24'h1, 2'd2));
        hit = 1'b0;
        for (int i = 0; i < 1100 && !hit; i++) begin
            @(negedge clk);
            hit = (tb_cnt == 9'd300) && (cyc - valid_last > 600 || valid_last < 0 || cyc - valid_last < 400);
        end
        check("reach_cnt_300", 24'(hit), 24'h1);
        #2 rst = 1'b1;
        #1;
        check_reset_state("midframe_reset");
        stim_q.delete();
        exp_q.delete();
        clear_trackers();
        stim_q.push_back(mk("post_reset", 24'h7FFFFF, 24'h800000, 2'd2));
        repeat (2) @(posedge clk);
        #2;
        check_reset_state("reset_held");
        rst = 1'b0;
        target = frames_done + 3;
        wait_frames(target, "post_reset_frames");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
